// File: rtl/cache_mem_arbiter.sv
// Serialises icache fills and dcache fills/writebacks onto one pmem line port.
// Ties go round-robin; a sticky watchdog flags grants that never get pmem_resp.
module cache_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int LINE_W         = 256,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              timeout_err
);

    localparam int              WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    // state   | meaning
    // IDLE    | no grant; sample requests, load pmem registers on exit
    // GRANT_I | icache line fill in flight
    // GRANT_D | dcache fill or writeback in flight
    // RELEASE | one dead cycle so a lingering request is not re-granted
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic              timeout_q, timeout_d;
    logic              pmem_read_q, pmem_read_d;
    logic              pmem_write_q, pmem_write_d;
    logic [ADDR_W-1:0] pmem_addr_q, pmem_addr_d;
    logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;

    logic d_pend;
    logic pick_d;

    assign d_pend = d_read | d_write;
    // last_d_q remembers who was granted last; the other side wins a tie
    assign pick_d = d_pend & (~i_read | ~last_d_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_d_q     <= 1'b0;
            wd_cnt_q     <= '0;
            timeout_q    <= 1'b0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_addr_q  <= '0;
            pmem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_d_q     <= last_d_d;
            wd_cnt_q     <= wd_cnt_d;
            timeout_q    <= timeout_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            pmem_addr_q  <= pmem_addr_d;
            pmem_wdata_q <= pmem_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d_d     = last_d_q;
        wd_cnt_d     = wd_cnt_q;
        timeout_d    = timeout_q;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        pmem_addr_d  = pmem_addr_q;
        pmem_wdata_d = pmem_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (i_read | d_pend) begin
                    wd_cnt_d = '0;
                    last_d_d = pick_d;
                    if (pick_d) begin
                        // a write wins over a simultaneous read
                        state_d      = GRANT_D;
                        pmem_write_d = d_write;
                        pmem_read_d  = ~d_write;
                        pmem_addr_d  = d_address;
                        pmem_wdata_d = d_write ? d_wdata : '0;
                    end else begin
                        state_d      = GRANT_I;
                        pmem_read_d  = 1'b1;
                        pmem_write_d = 1'b0;
                        pmem_addr_d  = i_address;
                        pmem_wdata_d = '0;
                    end
                end
            end
            GRANT_I, GRANT_D: begin
                if (wd_cnt_q != WD_MAX) begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
                if (wd_cnt_d == WD_MAX) begin
                    timeout_d = 1'b1;
                end
                if (pmem_resp) begin
                    state_d      = RELEASE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    pmem_addr_d  = '0;
                    pmem_wdata_d = '0;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign i_resp       = (state_q == GRANT_I) & pmem_resp;
    assign d_resp       = (state_q == GRANT_D) & pmem_resp;
    assign i_rdata      = (state_q == GRANT_I) ? pmem_rdata : '0;
    assign d_rdata      = (state_q == GRANT_D) ? pmem_rdata : '0;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_addr_q;
    assign pmem_wdata   = pmem_wdata_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench: expected pmem transactions are queued as requests are driven
// and checked by a memory model as each grant appears on the pmem port.
module tb_cache_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int TMO    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read, d_read, d_write;
    logic [ADDR_W-1:0] i_address, d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] i_rdata, d_rdata;
    logic              i_resp, d_resp;
    logic              pmem_read, pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata, pmem_rdata;
    logic              pmem_resp;
    logic              timeout_err;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .timeout_err(timeout_err)
    );

    typedef struct {
        bit                is_d;
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
        logic [LINE_W-1:0] rdata;
    } txn_t;

    txn_t exp_q[$];
    txn_t cur;
    int   n_vec = 0, n_err = 0;
    int   n_grants = 0, resp_i_cnt = 0, resp_d_cnt = 0;
    int   ei = 0, ed = 0, eg = 0;
    bit   mem_en = 1'b1;
    int   mem_lat = 5;
    bit   stray_req = 1'b0;
    bit   prev_strobe = 1'b0;
    bit   strobe;
    int   hi_cnt = 0;

    task automatic check(input string tag, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic txn_t mk(input bit is_d, input bit wr, input logic [ADDR_W-1:0] a,
                                input logic [LINE_W-1:0] wd, input logic [LINE_W-1:0] rd);
        txn_t t;
        t.is_d = is_d; t.wr = wr; t.addr = a; t.wdata = wd; t.rdata = rd;
        return t;
    endfunction

    // memory model and pmem-side scoreboard check
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp  = 1'b0;
            pmem_rdata = '0;
            strobe = pmem_read | pmem_write;
            if (strobe && !prev_strobe) begin
                hi_cnt = 0;
                n_grants++;
                check("grant_expected", LINE_W'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) cur = exp_q.pop_front();
            end
            if (strobe) begin
                hi_cnt++;
                check("pmem_address", pmem_address, cur.addr);
                check("pmem_write", pmem_write, cur.wr);
                check("pmem_read", pmem_read, !cur.wr);
                if (cur.wr) check("pmem_wdata", pmem_wdata, cur.wdata);
                if (mem_en && hi_cnt >= mem_lat) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = cur.rdata;
                    #1;
                    check("i_resp", i_resp, !cur.is_d);
                    check("d_resp", d_resp, cur.is_d);
                    check("i_rdata", i_rdata, cur.is_d ? '0 : cur.rdata);
                    check("d_rdata", d_rdata, cur.is_d ? cur.rdata : '0);
                end
            end else if (stray_req) begin
                pmem_resp  = 1'b1;
                pmem_rdata = {8{32'hDEAD_BEEF}};
                #1;
                check("stray_i_resp", i_resp, 0);
                check("stray_d_resp", d_resp, 0);
                check("stray_i_rdata", i_rdata, 0);
                check("stray_d_rdata", d_rdata, 0);
            end
            prev_strobe = strobe;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (i_resp) resp_i_cnt++;
            if (d_resp) resp_d_cnt++;
        end
    end

    task automatic wait_resp(input string tag, input bit which_d, input int target);
        int k = 0;
        while ((which_d ? resp_d_cnt : resp_i_cnt) < target && k < 200) begin
            @(negedge clk);
            #3;
            k++;
        end
        check(tag, which_d ? resp_d_cnt : resp_i_cnt, target);
    endtask

    task automatic wait_grants(input string tag, input int target);
        int k = 0;
        while (n_grants < target && k < 200) begin
            @(negedge clk);
            #3;
            k++;
        end
        check(tag, n_grants, target);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b0;
        i_read = 0; i_address = '0; d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_pmem_read", pmem_read, 0);
        check("rst_pmem_write", pmem_write, 0);
        check("rst_pmem_address", pmem_address, 0);
        check("rst_pmem_wdata", pmem_wdata, 0);
        check("rst_i_resp", i_resp, 0);
        check("rst_d_resp", d_resp, 0);
        check("rst_timeout", timeout_err, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // tie after reset: D, I, D, I
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) exp_q.push_back(mk(1, 0, 32'h2000, '0, {8{32'hD000_0000 + k}}));
            else            exp_q.push_back(mk(0, 0, 32'h3000, '0, {8{32'h1000_0000 + k}}));
        end
        i_read = 1; i_address = 32'h3000; d_read = 1; d_address = 32'h2000;
        eg += 4;
        wait_grants("tie_grants", eg);
        i_read = 0; d_read = 0;
        ei += 2; ed += 2;
        wait_resp("tie_i_resp", 0, ei);
        wait_resp("tie_d_resp", 1, ed);
        settle();

        // icache fill, latency and single-cycle resp
        exp_q.push_back(mk(0, 0, 32'h60, '0, {64{4'hA}}));
        i_read = 1; i_address = 32'h0000_0060;
        @(negedge clk); check("no_comb_path", pmem_read, 0);
        @(negedge clk); check("grant_latency", pmem_read, 1);
        eg++; ei++;
        wait_resp("icache_resp", 0, ei);
        @(posedge clk); #1; i_read = 0;
        repeat (4) @(negedge clk);
        check("icache_one_pulse", resp_i_cnt, ei);
        check("icache_d_quiet", resp_d_cnt, ed);
        settle();

        // dcache writeback with inputs changing mid-grant
        exp_q.push_back(mk(1, 1, 32'h1000, {8{32'h1234_5678}}, '0));
        d_write = 1; d_address = 32'h0000_1000; d_wdata = {8{32'h1234_5678}};
        repeat (2) @(negedge clk);
        d_wdata = ~d_wdata; d_address = 32'hFFFF_0000;
        eg++; ed++;
        wait_resp("dwrite_resp", 1, ed);
        @(posedge clk); #1; d_write = 0;
        repeat (4) @(negedge clk);
        check("dwrite_one_pulse", resp_d_cnt, ed);
        check("dwrite_i_quiet", resp_i_cnt, ei);
        settle();

        // late release: request held through the RELEASE cycle
        exp_q.push_back(mk(0, 0, 32'h80, '0, {8{32'h5A5A_A5A5}}));
        i_read = 1; i_address = 32'h80;
        eg++; ei++;
        wait_resp("late_resp", 0, ei);
        @(posedge clk); @(posedge clk); #1; i_read = 0;
        repeat (6) @(negedge clk);
        check("late_no_regrant", n_grants, eg);
        check("late_queue_empty", exp_q.size(), 0);
        settle();

        // pmem_resp while idle is ignored
        stray_req = 1;
        @(negedge clk); #3; stray_req = 0;
        repeat (4) @(negedge clk);
        check("stray_no_grant", n_grants, eg);
        check("stray_i_cnt", resp_i_cnt, ei);
        check("stray_d_cnt", resp_d_cnt, ed);
        check("pre_hang_timeout", timeout_err, 0);
        settle();

        // hang: watchdog sets after TMO cycles, transaction still completes
        mem_en = 0;
        exp_q.push_back(mk(0, 0, 32'h100, '0, {8{32'h0BAD_CAFE}}));
        i_read = 1; i_address = 32'h100;
        @(posedge clk);
        repeat (TMO - 1) @(posedge clk);
        @(negedge clk); check("timeout_before", timeout_err, 0);
        @(posedge clk);
        @(negedge clk); check("timeout_at", timeout_err, 1);
        check("hang_read_held", pmem_read, 1);
        #1; mem_en = 1;
        eg++; ei++;
        wait_resp("hang_resp", 0, ei);
        @(posedge clk); #1; i_read = 0;
        repeat (3) @(negedge clk);
        check("timeout_sticky", timeout_err, 1);
        settle();

        // reset in the middle of a dcache grant
        mem_en = 0;
        exp_q.push_back(mk(1, 1, 32'h4000, {8{32'hCAFE_F00D}}, '0));
        d_write = 1; d_address = 32'h4000; d_wdata = {8{32'hCAFE_F00D}};
        repeat (2) @(negedge clk);
        eg++;
        check("mid_grant_write", pmem_write, 1);
        #1; rst = 1'b0;
        #1;
        check("arst_pmem_write", pmem_write, 0);
        check("arst_pmem_read", pmem_read, 0);
        check("arst_pmem_address", pmem_address, 0);
        check("arst_pmem_wdata", pmem_wdata, 0);
        check("arst_d_resp", d_resp, 0);
        check("arst_timeout", timeout_err, 0);
        d_write = 0; d_wdata = '0;
        @(negedge clk); rst = 1'b1; mem_en = 1;
        @(posedge clk); #1;
        check("arst_no_resp", resp_d_cnt, ed);
        exp_q.push_back(mk(1, 0, 32'h5000, '0, {8{32'h5555_0001}}));
        exp_q.push_back(mk(0, 0, 32'h6000, '0, {8{32'h6666_0002}}));
        i_read = 1; i_address = 32'h6000; d_read = 1; d_address = 32'h5000;
        eg += 2;
        wait_grants("retie_grants", eg);
        i_read = 0; d_read = 0;
        ei++; ed++;
        wait_resp("retie_i_resp", 0, ei);
        wait_resp("retie_d_resp", 1, ed);
        settle();
        check("final_timeout", timeout_err, 0);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_grants", n_grants, eg);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Arbitrates the instruction cache and data cache onto the single 256-bit physical-memory line port that mp3 exposes as pmem_*.
- Sits directly between the two caches and the pmem pins driven by the testbench memory model.
- Serialises line fills and writebacks, one transaction at a time.
- Uses round-robin tie-breaking and carries a hang watchdog for verification.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 256, cacheline width in bits.
- TIMEOUT_CYCLES, 4096, cycles a granted transaction may wait for pmem_resp before timeout_err sets.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- i_read  in  1  icache line-fill request
- i_address  in  ADDR_W  icache line address
- i_rdata  out  LINE_W  fill data to icache
- i_resp  out  1  icache transaction complete
- d_read  in  1  dcache line-fill request
- d_write  in  1  dcache writeback request
- d_address  in  ADDR_W  dcache line address
- d_wdata  in  LINE_W  writeback data
- d_rdata  out  LINE_W  fill data to dcache
- d_resp  out  1  dcache transaction complete
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_address  out  ADDR_W  memory line address
- pmem_wdata  out  LINE_W  memory write data
- pmem_rdata  in  LINE_W  memory read data
- pmem_resp  in  1  memory transaction complete
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- State machine: IDLE, GRANT_I, GRANT_D, RELEASE.
- Reset (rst=0, asynchronous):
  - state=IDLE, last_grant=I, so D wins the first tie.
  - wd_cnt=0, timeout_err=0.
  - pmem_read, pmem_write, pmem_address and pmem_wdata all 0.
  - i_resp=0, d_resp=0.
  - A reset mid-transaction abandons the transaction with no response issued.
- pmem_read, pmem_write, pmem_address and pmem_wdata are registered. They are loaded on the edge that leaves IDLE and held constant for the whole grant.
- IDLE transitions:
  - Only i pending (i_read) -> GRANT_I.
  - Only d pending (d_read|d_write) -> GRANT_D.
  - Both pending -> grant the client not equal to last_grant.
  - Neither pending -> stay in IDLE.
  - last_grant updates on the grant edge.
- Grant latency: a request sampled in IDLE at edge N puts the pmem strobe high from N+1. No combinational path exists from request inputs to pmem outputs.
- GRANT_I: pmem_read=1, pmem_address=latched i_address, pmem_write=0.
- GRANT_D:
  - If d_write was high at grant: pmem_write=1, pmem_wdata=latched d_wdata.
  - Otherwise pmem_read=1.
  - d_read and d_write both high is illegal; write wins and the read is ignored for that transaction.
- Completion:
  - In GRANT_x, when pmem_resp=1, the x_resp output equals 1 in the same cycle (combinational).
  - x_rdata = pmem_rdata combinationally while in GRANT_x. It is 0 in all other states.
  - The other client's resp stays 0.
  - On that edge: state -> RELEASE, and pmem strobes clear to 0.
- RELEASE: lasts exactly one cycle, grants nothing, then -> IDLE. This absorbs a client request still high in the cycle after its resp.
- Back-to-back: continuous requests from both clients alternate I, D, I, D. The minimum pmem strobe gap is 2 cycles (RELEASE + IDLE).
- Clients must hold request, address and wdata stable until resp. Changes during a grant are ignored because the values are latched.
- Watchdog:
  - wd_cnt clears on entering GRANT_x and increments each cycle in GRANT_x, saturating at TIMEOUT_CYCLES.
  - When wd_cnt reaches TIMEOUT_CYCLES, timeout_err sets. It stays set until reset.
  - The transaction is not aborted; the arbiter keeps waiting for pmem_resp.
- pmem_resp outside GRANT_x is ignored and produces no client resp.

Test Plan:
- Icache only, i_read=1, i_address=0x0000_0060, memory responds 5 cycles after pmem_read rises with rdata=0xAA..AA -> pmem_read rises 1 cycle after the request with pmem_address=0x60 and pmem_write=0; i_resp=1 for exactly 1 cycle with i_rdata=0xAA..AA; d_resp stays 0.
- Dcache writeback, d_write=1, d_address=0x0000_1000, d_wdata=0x1234..; d_wdata changes mid-grant -> pmem_write=1 with the original wdata and address 0x1000 throughout; d_resp pulses once.
- Tie after reset, i_read and d_read both rise in the same cycle and are held -> dcache is granted first, then icache; with both held continuously, grants alternate D, I, D, I over 4 transactions.
- Late release, a client keeps its request high 1 cycle after resp -> RELEASE absorbs it; no duplicate pmem transaction occurs.
- Hang, TIMEOUT_CYCLES=16 and memory never responds -> timeout_err=1 exactly 16 cycles after grant; pmem_read stays high; a later pmem_resp completes normally and timeout_err stays 1.
- Reset mid-grant, rst=0 during GRANT_D -> all outputs 0 asynchronously; after release the next tie grants D first; timeout_err=0.
